// File: rtl/ahb_slave_port_arbiter.sv
// Round-robin address-phase arbiter for one AHB multilayer slave port; grant registered, 1-cycle grant latency.
// Slave HREADYOUT low freezes all state; losing requesters see o_mst_wait until granted.
module ahb_slave_port_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int MIDX_W      = $clog2(NUM_MASTERS)
) (
  input  logic                     i_hclk,
  input  logic                     i_hresetn,
  input  logic [NUM_MASTERS-1:0]   i_hsel_m,
  input  logic [2*NUM_MASTERS-1:0] i_htrans_m,
  input  logic [NUM_MASTERS-1:0]   i_hmastlock_m,
  input  logic                     i_hreadyout_s,
  output logic [NUM_MASTERS-1:0]   o_addr_gnt,
  output logic [MIDX_W-1:0]        o_addr_midx,
  output logic [MIDX_W-1:0]        o_data_midx,
  output logic                     o_data_vld,
  output logic                     o_hsel_s,
  output logic [NUM_MASTERS-1:0]   o_mst_wait
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [NUM_MASTERS-1:0] r_gnt;
  logic [MIDX_W-1:0]      r_rr_ptr;
  logic [MIDX_W-1:0]      r_dph;
  logic                   r_dvld;
  logic                   r_lock;

  logic [NUM_MASTERS-1:0] w_req;
  logic [MIDX_W-1:0]      w_own_idx;
  logic [1:0]             w_own_trans;
  logic                   w_own_sel;
  logic                   w_own_lock;
  logic                   w_own_vld;
  logic                   w_own_req;
  logic                   w_hold;
  logic                   w_win_vld;
  logic [MIDX_W-1:0]      w_win_idx;
  logic [MIDX_W-1:0]      w_ptr_nxt;
  logic [NUM_MASTERS-1:0] w_win_oh;

  always_comb begin
    for (int k = 0; k < NUM_MASTERS; k++) begin
      w_req[k] = i_hsel_m[k] & i_htrans_m[2*k+1];
    end
  end

  always_comb begin
    w_own_idx   = '0;
    w_own_trans = HTRANS_IDLE;
    w_own_sel   = 1'b0;
    w_own_lock  = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (r_gnt[k]) begin
        w_own_idx   = MIDX_W'(k);
        w_own_trans = i_htrans_m[2*k +: 2];
        w_own_sel   = i_hsel_m[k];
        w_own_lock  = i_hmastlock_m[k];
      end
    end
  end

  assign w_own_vld = |r_gnt;
  assign w_own_req = w_own_sel & w_own_trans[1];

  // SEQ and BUSY both have bit 0 set: the owner is mid-burst and must not be split.
  assign w_hold = w_own_vld & ((w_own_sel & w_own_trans[0]) |
                               w_own_lock |
                               (r_lock & (w_own_trans != HTRANS_IDLE)));

  always_comb begin
    int c;
    c         = 0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      c = (int'(r_rr_ptr) + i) % NUM_MASTERS;
      if (!w_win_vld && w_req[c]) begin
        w_win_vld = 1'b1;
        w_win_idx = MIDX_W'(c);
      end
    end
  end

  assign w_ptr_nxt = (int'(w_win_idx) == NUM_MASTERS - 1) ? '0 : w_win_idx + MIDX_W'(1);
  assign w_win_oh  = w_win_vld ? (NUM_MASTERS'(1) << w_win_idx) : '0;

  always_ff @(posedge i_hclk or negedge i_hresetn) begin
    if (!i_hresetn) begin
      r_gnt    <= '0;
      r_rr_ptr <= '0;
      r_dph    <= '0;
      r_dvld   <= 1'b0;
      r_lock   <= 1'b0;
    end else if (i_hreadyout_s) begin
      r_lock <= w_own_vld & w_own_lock;
      r_dvld <= w_own_vld & w_own_req;
      r_dph  <= w_own_idx;
      if (!w_hold) begin
        r_gnt <= w_win_oh;
        if (w_win_vld) r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign o_addr_gnt  = r_gnt;
  assign o_addr_midx = w_own_idx;
  assign o_data_midx = r_dph;
  assign o_data_vld  = r_dvld;
  assign o_hsel_s    = |(r_gnt & i_hsel_m);
  assign o_mst_wait  = w_req & ~r_gnt;

endmodule

// File: tb/tb_ahb_slave_port_arbiter.sv
// Directed bench for ahb_slave_port_arbiter with three masters; expectations are hand-derived per cycle.
module tb_ahb_slave_port_arbiter;

  localparam int N = 3;
  localparam int W = 2;
  localparam logic [1:0] ID = 2'b00, BY = 2'b01, NS = 2'b10, SQ = 2'b11;

  logic           i_hclk = 1'b0;
  logic           i_hresetn;
  logic [N-1:0]   i_hsel_m;
  logic [2*N-1:0] i_htrans_m;
  logic [N-1:0]   i_hmastlock_m;
  logic           i_hreadyout_s;
  logic [N-1:0]   o_addr_gnt;
  logic [W-1:0]   o_addr_midx;
  logic [W-1:0]   o_data_midx;
  logic           o_data_vld;
  logic           o_hsel_s;
  logic [N-1:0]   o_mst_wait;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_slave_port_arbiter #(.NUM_MASTERS(N), .MIDX_W(W)) dut (
    .i_hclk        (i_hclk),
    .i_hresetn     (i_hresetn),
    .i_hsel_m      (i_hsel_m),
    .i_htrans_m    (i_htrans_m),
    .i_hmastlock_m (i_hmastlock_m),
    .i_hreadyout_s (i_hreadyout_s),
    .o_addr_gnt    (o_addr_gnt),
    .o_addr_midx   (o_addr_midx),
    .o_data_midx   (o_data_midx),
    .o_data_vld    (o_data_vld),
    .o_hsel_s      (o_hsel_s),
    .o_mst_wait    (o_mst_wait)
  );

  always #5 i_hclk = ~i_hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after a rising edge and settle 2ns before checks.
  task automatic drv(input logic [N-1:0] sel, input logic [2*N-1:0] trans,
                     input logic [N-1:0] lock, input logic rdy);
    i_hsel_m      = sel;
    i_htrans_m    = trans;
    i_hmastlock_m = lock;
    i_hreadyout_s = rdy;
    #2;
  endtask

  task automatic tick();
    @(posedge i_hclk);
    #1;
  endtask

  task automatic do_reset();
    i_hresetn     = 1'b0;
    i_hsel_m      = '0;
    i_htrans_m    = '0;
    i_hmastlock_m = '0;
    i_hreadyout_s = 1'b1;
    repeat (2) @(posedge i_hclk);
    @(negedge i_hclk);
    i_hresetn = 1'b1;
  endtask

  initial begin
    do_reset();
    #1;
    chk("rst_gnt",   32'(o_addr_gnt),  0);
    chk("rst_midx",  32'(o_addr_midx), 0);
    chk("rst_dmidx", 32'(o_data_midx), 0);
    chk("rst_dvld",  32'(o_data_vld),  0);
    chk("rst_hsel",  32'(o_hsel_s),    0);
    chk("rst_wait",  32'(o_mst_wait),  0);

    // Single request from M1; M0 drives BUSY as a non-owner and must be ignored.
    drv(3'b011, {ID, NS, BY}, 3'b000, 1'b1);
    chk("single_wait0", 32'(o_mst_wait), 32'b010);
    chk("single_gnt0",  32'(o_addr_gnt), 0);
    tick();
    drv(3'b011, {ID, NS, BY}, 3'b000, 1'b1);
    chk("single_gnt1",  32'(o_addr_gnt),  32'b010);
    chk("single_midx1", 32'(o_addr_midx), 1);
    chk("single_wait1", 32'(o_mst_wait),  0);
    chk("single_hsel1", 32'(o_hsel_s),    1);
    chk("single_dvld1", 32'(o_data_vld),  0);
    tick();
    chk("single_dmidx2", 32'(o_data_midx), 1);
    chk("single_dvld2",  32'(o_data_vld),  1);
    chk("single_gnt2",   32'(o_addr_gnt),  32'b010);

    // All three request continuously: 001, 010, 100, 001, ...
    do_reset();
    drv(3'b111, {NS, NS, NS}, 3'b000, 1'b1);
    chk("rr_wait0", 32'(o_mst_wait), 32'b111);
    for (int i = 0; i < 6; i++) begin
      logic [N-1:0] e;
      tick();
      e = N'(1) << (i % 3);
      chk("rr_gnt",  32'(o_addr_gnt), 32'(e));
      chk("rr_wait", 32'(o_mst_wait), 32'(3'b111 & ~e));
    end

    // INCR4 from M2; M0 joins from the second beat and waits for M2 to go IDLE.
    do_reset();
    drv(3'b100, {NS, ID, ID}, 3'b000, 1'b1);
    tick();
    drv(3'b100, {NS, ID, ID}, 3'b000, 1'b1);
    chk("burst_b1_gnt", 32'(o_addr_gnt), 32'b100);
    tick();
    for (int b = 2; b <= 4; b++) begin
      drv(3'b101, {SQ, ID, NS}, 3'b000, 1'b1);
      chk("burst_seq_gnt",  32'(o_addr_gnt), 32'b100);
      chk("burst_seq_wait", 32'(o_mst_wait), 32'b001);
      chk("burst_seq_dvld", 32'(o_data_vld), 1);
      tick();
    end
    drv(3'b001, {ID, ID, NS}, 3'b000, 1'b1);
    chk("burst_end_gnt",   32'(o_addr_gnt),  32'b100);
    chk("burst_end_dmidx", 32'(o_data_midx), 2);
    tick();
    chk("burst_m0_gnt",  32'(o_addr_gnt),  32'b001);
    chk("burst_m0_midx", 32'(o_addr_midx), 0);
    chk("burst_dvld",    32'(o_data_vld),  0);

    // Locked M0: NONSEQ, IDLE, NONSEQ under lock, then IDLE with lock dropped.
    do_reset();
    drv(3'b011, {ID, NS, NS}, 3'b001, 1'b1);
    tick();
    drv(3'b011, {ID, NS, NS}, 3'b001, 1'b1);
    chk("lock_a_gnt",  32'(o_addr_gnt), 32'b001);
    chk("lock_a_wait", 32'(o_mst_wait), 32'b010);
    tick();
    drv(3'b011, {ID, NS, ID}, 3'b001, 1'b1);
    chk("lock_idle_gnt", 32'(o_addr_gnt), 32'b001);
    tick();
    drv(3'b011, {ID, NS, NS}, 3'b001, 1'b1);
    chk("lock_b_gnt",  32'(o_addr_gnt), 32'b001);
    chk("lock_b_wait", 32'(o_mst_wait), 32'b010);
    tick();
    drv(3'b010, {ID, NS, ID}, 3'b000, 1'b1);
    chk("lock_rel_gnt", 32'(o_addr_gnt), 32'b001);
    tick();
    chk("lock_m1_gnt",  32'(o_addr_gnt), 32'b010);
    chk("lock_m1_wait", 32'(o_mst_wait), 0);

    // Three wait states during M1's data phase while M2 requests.
    do_reset();
    drv(3'b010, {ID, NS, ID}, 3'b000, 1'b1);
    tick();
    drv(3'b010, {ID, NS, ID}, 3'b000, 1'b1);
    tick();
    for (int w = 0; w < 3; w++) begin
      drv(3'b100, {NS, ID, ID}, 3'b000, 1'b0);
      chk("ws_gnt",   32'(o_addr_gnt),  32'b010);
      chk("ws_dmidx", 32'(o_data_midx), 1);
      chk("ws_dvld",  32'(o_data_vld),  1);
      chk("ws_wait",  32'(o_mst_wait),  32'b100);
      tick();
    end
    drv(3'b100, {NS, ID, ID}, 3'b000, 1'b1);
    chk("ws_last_gnt", 32'(o_addr_gnt), 32'b010);
    tick();
    chk("ws_m2_gnt",  32'(o_addr_gnt),  32'b100);
    chk("ws_m2_midx", 32'(o_addr_midx), 2);
    chk("ws_dvld_end", 32'(o_data_vld), 0);

    // Reset asserted mid-burst clears outputs without a clock edge.
    do_reset();
    drv(3'b100, {NS, ID, ID}, 3'b000, 1'b1);
    tick();
    drv(3'b100, {NS, ID, ID}, 3'b000, 1'b1);
    tick();
    drv(3'b100, {SQ, ID, ID}, 3'b000, 1'b1);
    chk("arst_pre_gnt",  32'(o_addr_gnt), 32'b100);
    chk("arst_pre_dvld", 32'(o_data_vld), 1);
    #1;
    i_hresetn = 1'b0;
    #1;
    chk("arst_gnt",  32'(o_addr_gnt), 0);
    chk("arst_dvld", 32'(o_data_vld), 0);
    chk("arst_hsel", 32'(o_hsel_s),   0);
    @(negedge i_hclk);
    i_hresetn = 1'b1;
    drv(3'b101, {NS, ID, NS}, 3'b000, 1'b1);
    chk("arst_wait", 32'(o_mst_wait), 32'b101);
    tick();
    chk("arst_m0_gnt", 32'(o_addr_gnt), 32'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
